// File: rtl/warmboot_pkg.sv
// Shared types and constants for the warmboot boot-sequencing controller.
package warmboot_pkg;

  localparam int unsigned IMG_W        = 2;
  localparam int unsigned SETUP_CYCLES = 2;

  typedef enum logic [2:0] {
    StHold,
    StRun,
    StDetach,
    StSetup,
    StBoot
  } state_e;

  // Counter must hold the larger of the two programmable delays without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/warmboot_ctrl.sv
// Boot sequencer: holds the core in reset until PLL lock is stable, then on request
// detaches USB and drives SB_WARMBOOT with the selected image.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int unsigned NUM_IMAGES    = 4,
  parameter int unsigned RESET_CYCLES  = 4800,
  parameter int unsigned DETACH_CYCLES = 480000
) (
  input  logic             clk_usb,
  input  logic             reset_n,
  input  logic             pll_lock,
  input  logic             boot_req,
  input  logic [IMG_W-1:0] boot_image,
  output logic             core_reset,
  output logic             usb_pu,
  output logic [IMG_W-1:0] wb_s,
  output logic             wb_boot,
  output logic             boot_err,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(RESET_CYCLES, DETACH_CYCLES);

  localparam logic [CntW-1:0]  ResetLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0]  DetachLast = CntW'(DETACH_CYCLES - 1);
  localparam logic [CntW-1:0]  SetupLast  = CntW'(SETUP_CYCLES - 1);
  localparam logic [IMG_W:0]   NumImg     = (IMG_W + 1)'(NUM_IMAGES);

  logic            lock_s;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  sync_2ff u_lock_sync (
    .clk_i  (clk_usb),
    .rst_ni (reset_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHold;
      cnt_q      <= '0;
      core_reset <= 1'b1;
      usb_pu     <= 1'b0;
      wb_s       <= '0;
      wb_boot    <= 1'b0;
      boot_err   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      boot_err <= 1'b0;
      case (state_q)
        StHold: begin
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == ResetLast) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            core_reset <= 1'b0;
            usb_pu     <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          // Lock loss takes priority and silently drops a coincident request.
          if (!lock_s) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            core_reset <= 1'b1;
            usb_pu     <= 1'b0;
            busy       <= 1'b1;
          end else if (boot_req) begin
            if ({1'b0, boot_image} < NumImg) begin
              state_q    <= StDetach;
              cnt_q      <= '0;
              wb_s       <= boot_image;
              core_reset <= 1'b1;
              usb_pu     <= 1'b0;
              busy       <= 1'b1;
            end else begin
              boot_err <= 1'b1;
            end
          end
        end
        StDetach: begin
          if (cnt_q == DetachLast) begin
            state_q <= StSetup;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            state_q <= StBoot;
            wb_boot <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBoot: begin
          wb_boot <= 1'b1;
        end
        default: begin
          state_q <= StHold;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed self-checking bench for warmboot_ctrl with short reset/detach delays.
module tb_warmboot_ctrl;

  logic       clk_usb;
  logic       reset_n;
  logic       pll_lock;
  logic       boot_req;
  logic [1:0] boot_image;
  logic       core_reset;
  logic       usb_pu;
  logic [1:0] wb_s;
  logic       wb_boot;
  logic       boot_err;
  logic       busy;

  logic       boot_req_b;
  logic [1:0] boot_image_b;
  logic       core_reset_b;
  logic       usb_pu_b;
  logic [1:0] wb_s_b;
  logic       wb_boot_b;
  logic       boot_err_b;
  logic       busy_b;

  int n_cmp;
  int n_err;

  warmboot_ctrl #(
    .NUM_IMAGES    (4),
    .RESET_CYCLES  (8),
    .DETACH_CYCLES (16)
  ) dut (
    .clk_usb    (clk_usb),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .boot_req   (boot_req),
    .boot_image (boot_image),
    .core_reset (core_reset),
    .usb_pu     (usb_pu),
    .wb_s       (wb_s),
    .wb_boot    (wb_boot),
    .boot_err   (boot_err),
    .busy       (busy)
  );

  warmboot_ctrl #(
    .NUM_IMAGES    (2),
    .RESET_CYCLES  (8),
    .DETACH_CYCLES (16)
  ) dut_b (
    .clk_usb    (clk_usb),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .boot_req   (boot_req_b),
    .boot_image (boot_image_b),
    .core_reset (core_reset_b),
    .usb_pu     (usb_pu_b),
    .wb_s       (wb_s_b),
    .wb_boot    (wb_boot_b),
    .boot_err   (boot_err_b),
    .busy       (busy_b)
  );

  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_usb);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    pll_lock     = 1'b0;
    boot_req     = 1'b0;
    boot_image   = 2'd0;
    boot_req_b   = 1'b0;
    boot_image_b = 2'd0;
    tick(3);

    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_usb_pu", usb_pu, 0);
    check_eq("rst_wb_s", wb_s, 0);
    check_eq("rst_wb_boot", wb_boot, 0);
    check_eq("rst_boot_err", boot_err, 0);
    check_eq("rst_busy", busy, 1);

    reset_n = 1'b1;
    tick(3);
    check_eq("nolock_hold", core_reset, 1);

    // Lock rises in cycle L; release expected after edge L+10.
    pll_lock = 1'b1;
    tick(9);
    check_eq("rel_early_core_reset", core_reset, 1);
    check_eq("rel_early_busy", busy, 1);
    tick(1);
    check_eq("rel_core_reset", core_reset, 0);
    check_eq("rel_usb_pu", usb_pu, 1);
    check_eq("rel_busy", busy, 0);
    check_eq("rel_b_core_reset", core_reset_b, 0);

    // Out-of-range image on the two-image instance.
    boot_req_b   = 1'b1;
    boot_image_b = 2'd3;
    tick(1);
    boot_req_b = 1'b0;
    check_eq("err_pulse", boot_err_b, 1);
    check_eq("err_usb_pu", usb_pu_b, 1);
    check_eq("err_wb_s", wb_s_b, 0);
    check_eq("err_busy", busy_b, 0);
    tick(1);
    check_eq("err_pulse_end", boot_err_b, 0);
    check_eq("err_still_run", usb_pu_b, 1);
    check_eq("err_core_reset", core_reset_b, 0);
    check_eq("err_no_boot", wb_boot_b, 0);

    // Lock drops in cycle M; lock_s is low in M+2 when the request is presented.
    pll_lock = 1'b0;
    tick(2);
    check_eq("drop_still_run", core_reset, 0);
    boot_req   = 1'b1;
    boot_image = 2'd1;
    tick(1);
    boot_req = 1'b0;
    check_eq("coinc_core_reset", core_reset, 1);
    check_eq("coinc_usb_pu", usb_pu, 0);
    check_eq("coinc_boot_err", boot_err, 0);
    check_eq("coinc_wb_s", wb_s, 0);
    check_eq("coinc_busy", busy, 1);
    tick(20);
    check_eq("coinc_no_boot", wb_boot, 0);
    check_eq("coinc_wb_s_late", wb_s, 0);

    // Lock returns at G, glitches low in G+5, back at G+6: release after G+16.
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(4);
    check_eq("glitch_g10", core_reset, 1);
    tick(5);
    check_eq("glitch_g15", core_reset, 1);
    tick(1);
    check_eq("glitch_rel_core_reset", core_reset, 0);
    check_eq("glitch_rel_usb_pu", usb_pu, 1);

    // Boot image 2 requested in cycle N.
    boot_req   = 1'b1;
    boot_image = 2'd2;
    tick(1);
    boot_req = 1'b0;
    check_eq("boot_usb_pu", usb_pu, 0);
    check_eq("boot_core_reset", core_reset, 1);
    check_eq("boot_wb_s", wb_s, 2);
    check_eq("boot_busy", busy, 1);
    check_eq("boot_wb_boot_early", wb_boot, 0);
    pll_lock = 1'b0;
    tick(5);
    pll_lock = 1'b1;
    tick(12);
    check_eq("boot_n18_wb_boot", wb_boot, 0);
    check_eq("boot_n18_wb_s", wb_s, 2);
    check_eq("boot_n18_usb_pu", usb_pu, 0);
    tick(1);
    check_eq("boot_n19_wb_boot", wb_boot, 1);
    boot_req   = 1'b1;
    boot_image = 2'd3;
    tick(1);
    boot_req = 1'b0;
    check_eq("boot_ignore_req", boot_err, 0);
    tick(5);
    check_eq("boot_hold_wb_boot", wb_boot, 1);
    check_eq("boot_hold_wb_s", wb_s, 2);
    check_eq("boot_hold_core_reset", core_reset, 1);
    check_eq("boot_hold_usb_pu", usb_pu, 0);
    check_eq("boot_hold_busy", busy, 1);

    // Asynchronous reset out of BOOT.
    reset_n = 1'b0;
    #1;
    check_eq("rb_wb_boot", wb_boot, 0);
    check_eq("rb_wb_s", wb_s, 0);
    check_eq("rb_core_reset", core_reset, 1);
    check_eq("rb_usb_pu", usb_pu, 0);
    check_eq("rb_busy", busy, 1);
    tick(2);
    reset_n = 1'b1;
    tick(9);
    check_eq("rb_rel_early", core_reset, 1);
    tick(1);
    check_eq("rb_rel_core_reset", core_reset, 0);
    check_eq("rb_rel_usb_pu", usb_pu, 1);
    check_eq("rb_rel_busy", busy, 0);
    check_eq("rb_rel_wb_boot", wb_boot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/warmboot_ctrl.md
# warmboot_ctrl

Parametrised boot-sequencing block between the PLL/SB_WARMBOOT primitives and the bootloader core on every board top.
- Holds the core in reset until the 48 MHz PLL has been locked for a programmable time, then enables the USB pull-up.
- On a boot request, detaches from USB for a programmable period before driving the warmboot primitive with a selectable image index.
- Replaces the hard-wired constant reset, pull-up and fixed-image warmboot of earlier board tops.

## Interface
Parameters:
- NUM_IMAGES, 4: selectable warmboot images, legal 2..4; IMG_W = 2.
- RESET_CYCLES, 4800: locked cycles before core release (100 us at 48 MHz), ≥ 2.
- DETACH_CYCLES, 480000: pull-up-low cycles before warmboot (10 ms), ≥ 1.

Ports:
- clk_usb  in  1  48 MHz PLL output; only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous to clk_usb.
- boot_req  in  1  one-cycle request from the bootloader core.
- boot_image  in  2  image index, sampled with boot_req.
- core_reset  out  1  active-high reset to the bootloader core.
- usb_pu  out  1  USB D+ pull-up enable.
- wb_s  out  2  to SB_WARMBOOT {S1,S0}.
- wb_boot  out  1  to SB_WARMBOOT BOOT.
- boot_err  out  1  one-cycle pulse: request rejected.
- busy  out  1  high in every state except RUN.

## Operation
- pll_lock passes through a 2-flop synchroniser; lock_s denotes its output.
- States: HOLD, RUN, DETACH, SETUP, BOOT.
- HOLD:
  - core_reset=1, usb_pu=0.
  - Counter increments while lock_s=1 and clears to 0 whenever lock_s=0.
  - When count = RESET_CYCLES-1 with lock_s=1, go to RUN.
- RUN:
  - core_reset=0, usb_pu=1.
  - lock_s=0 → HOLD next cycle; counter cleared.
  - boot_req=1 with boot_image < NUM_IMAGES → latch boot_image into wb_s, clear counter, go to DETACH.
  - boot_req=1 with boot_image ≥ NUM_IMAGES → stay in RUN, pulse boot_err for one cycle, wb_s unchanged.
  - lock loss and boot_req in the same cycle: lock loss wins, request is dropped, no boot_err.
- DETACH:
  - core_reset=1, usb_pu=0.
  - Counts DETACH_CYCLES cycles, then goes to SETUP.
  - lock_s is ignored; the sequence is committed once DETACH is entered.
- SETUP: exactly 2 cycles with wb_s stable and wb_boot=0, then BOOT.
- BOOT: wb_boot=1, absorbing state. Only reset_n or device reconfiguration leaves it.
- boot_req is ignored outside RUN.
- Counter width = clog2(max(RESET_CYCLES, DETACH_CYCLES)+1); the counter never wraps.

## Timing
- Reset values while reset_n=0: state HOLD, counter 0, core_reset=1, usb_pu=0, wb_s=0, wb_boot=0, boot_err=0, busy=1, synchroniser flops 0.
- Async assert; deassertion is used directly. The board top feeds reset_n from a reset synchroniser.
- reset_n asserted in any state, including mid-DETACH or BOOT, returns to HOLD immediately with the values above.
- Release: lock rises at pll_lock edge cycle L; lock_s is high from L+2.
  - core_reset falls and usb_pu rises at L+2+RESET_CYCLES.
  - Uninterrupted lock gives exactly RESET_CYCLES cycles in HOLD.
- Boot: boot_req sampled high at edge N.
  - From N+1: usb_pu=0, core_reset=1, wb_s valid.
  - wb_boot rises at N+1+DETACH_CYCLES+2 and stays high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package warmboot_pkg holds:
  - state enum (HOLD, RUN, DETACH, SETUP, BOOT);
  - IMG_W = 2;
  - SETUP_CYCLES = 2;
  - clog2-based counter-width function.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) synchronises pll_lock; it is reused later for button inputs.
- Board tops instantiate SB_PLL40_PAD, warmboot_ctrl, SB_WARMBOOT (BOOT/S1/S0 from wb_boot/wb_s) and the bootloader core.

## Test plan
All scenarios use RESET_CYCLES=8 and DETACH_CYCLES=16.
- Lock first high at cycle 10 → core_reset falls and usb_pu rises at cycle 20; busy falls the same cycle.
- Lock glitches low for 1 cycle after 5 locked cycles → counter restarts; release occurs 8 cycles after lock_s returns high.
- In RUN: boot_req with boot_image=2 at cycle N.
  - usb_pu=0 and core_reset=1 at N+1.
  - wb_s=2'b10 from N+1.
  - wb_boot=1 at N+19 and held high.
- NUM_IMAGES=2, boot_req with boot_image=3 → boot_err one-cycle pulse; state stays RUN; wb_s stays 0; usb_pu stays 1.
- Lock drop in RUN → HOLD; lock drop during DETACH → no effect, wb_boot still rises on schedule; lock drop coincident with boot_req → HOLD and no boot.
- reset_n pulsed low while in BOOT → all outputs return to reset values; normal release follows once lock is present.
